mem_arbiter: RTL

- Shares the single-ported, byte-addressable 64 KB memory (16-bit word, combinational read, write on rising edge) between the instruction-fetch port and the data-memory port of the processor.
- Sits between the fetch/memory pipeline stages and the memory instance.
- Serialises accesses, models a configurable access latency with a counter, and returns per-port done/stall handshakes.
- Read data is registered.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_arb_pick.sv | 33 +++
 rtl/mem_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory arbiter slice.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef logic port_id_t;

    localparam port_id_t PORT_IF = 1'b0;
    localparam port_id_t PORT_DM = 1'b1;

    localparam int unsigned MEM_ARB_LATENCY = 2;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between fetch and data ports.
// MEM_ARB_ROUND_ROBIN_EN: alternate on simultaneous requests instead of fixed DM priority.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic     if_req,
    input  logic     dm_req,
    input  port_id_t last_grant,
    output logic     grant_valid,
    output port_id_t grant
);

    always_comb begin
        grant_valid = if_req | dm_req;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (if_req && dm_req) begin
            grant = ~last_grant;
        end else if (dm_req) begin
            grant = PORT_DM;
        end else begin
            grant = PORT_IF;
        end
`else
        grant = dm_req ? PORT_DM : PORT_IF;
`endif
    end

`ifndef MEM_ARB_ROUND_ROBIN_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Serialises fetch and data accesses onto one single-ported memory with a fixed hold latency.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin arbitration (default: fixed DM priority).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned LATENCY = MEM_ARB_LATENCY
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic [15:0] if_rdata,
    output logic        if_done,
    output logic        if_stall,
    input  logic        dm_req,
    input  logic        dm_wr,
    input  logic [15:0] dm_addr,
    input  logic [15:0] dm_wdata,
    output logic [15:0] dm_rdata,
    output logic        dm_done,
    output logic        dm_stall,
    input  logic [15:0] mem_rdata,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_enable,
    output logic        mem_wr,
    input  logic        dump_in,
    output logic        mem_createdump
);

    localparam int unsigned CW = $clog2(LATENCY + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    port_id_t      owner;
    logic [15:0]   lat_addr;
    logic [15:0]   lat_wdata;
    logic          lat_wr;
    port_id_t      last_grant;
    logic          grant_valid;
    port_id_t      grant;

    mem_arb_pick u_pick (
        .if_req      (if_req),
        .dm_req      (dm_req),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            owner     <= PORT_IF;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_wr    <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        owner <= grant;
                        cnt   <= CNT_LOAD;
                        state <= ACCESS;
                        if (grant == PORT_DM) begin
                            lat_addr  <= dm_addr;
                            lat_wdata <= dm_wdata;
                            lat_wr    <= dm_wr;
                        end else begin
                            lat_addr  <= if_addr;
                            lat_wr    <= 1'b0;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        // Read data is captured on the same edge the memory is enabled.
                        if (!lat_wr) begin
                            if (owner == PORT_DM) begin
                                dm_rdata <= mem_rdata;
                            end else begin
                                if_rdata <= mem_rdata;
                            end
                        end
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= PORT_IF;
        end else if (state == IDLE && grant_valid) begin
            last_grant <= grant;
        end
    end
`else
    assign last_grant = PORT_IF;
`endif

    always_comb begin
        mem_addr       = lat_addr;
        mem_wdata      = lat_wdata;
        mem_wr         = (state == ACCESS) && lat_wr;
        mem_enable     = (state == ACCESS) && (cnt == '0);
        if_done        = (state == DONE) && (owner == PORT_IF);
        dm_done        = (state == DONE) && (owner == PORT_DM);
        if_stall       = if_req & ~if_done;
        dm_stall       = dm_req & ~dm_done;
        mem_createdump = dump_in;
    end

endmodule
